// File: rtl/mlp_seq_pkg.sv
// Shared types, default ENERGY2 coefficient set and width helpers for the
// sequential MLP engine.
`default_nettype none

package mlp_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    L0   = 2'd1,
    L1   = 2'd2,
    DONE = 2'd3
  } state_t;

  // Flat coefficient vectors: element k sits at bits [k*W +: W].
  // W0 element index is h*N_IN+i, W1 element index is o*N_HID+h.
  localparam logic [191:0] ENERGY2_W0 =
    192'hFCFCFDFDFCFCFDFD_0607070707070707_FCFCFCFCFCFCFCFC;
  localparam logic [47:0]  ENERGY2_B0 = 48'h0197_FFE5_01D9;
  localparam logic [71:0]  ENERGY2_W1 = 72'hFF20FF_14FF1E_14FE14;
  localparam logic [47:0]  ENERGY2_B1 = 48'h0284_0148_04B0;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int hid_acc_w(input int b_w, input int w_w,
                                   input int in_w, input int n_in);
    return b_w + w_w + in_w + $clog2(n_in) + 1;
  endfunction

  function automatic int out_acc_w(input int b_w, input int w_w,
                                   input int hid_w, input int n_hid);
    return max_int(b_w, w_w + hid_w + 1) + $clog2(n_hid) + 1;
  endfunction

  function automatic int cnt_w(input int a, input int b, input int c);
    return $clog2(max_int(max_int(a, b), c) + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mlp_argmax_acc.sv
// Running argmax over a stream of unsigned scores; ties keep the lowest index.
`default_nettype none

module mlp_argmax_acc #(
  parameter int SCORE_W = 42,
  parameter int IDX_W   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               update,
  input  logic [SCORE_W-1:0] score,
  input  logic [IDX_W-1:0]   idx,
  output logic [IDX_W-1:0]   best_idx
);

  logic [SCORE_W-1:0] best_score;

  // Scores are ReLU outputs, so a cleared best of zero lets index 0 win
  // whenever nothing strictly larger follows.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      best_score <= '0;
      best_idx   <= '0;
    end else if (clear) begin
      best_score <= '0;
      best_idx   <= '0;
    end else if (update && (score > best_score)) begin
      best_score <= score;
      best_idx   <= idx;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mlp_seq_engine.sv
// Two-layer MLP classifier evaluated one multiply-accumulate per cycle,
// followed by an argmax over the output scores.
`default_nettype none

module mlp_seq_engine
  import mlp_seq_pkg::*;
#(
  parameter int N_IN  = 8,
  parameter int IN_W  = 4,
  parameter int N_HID = 3,
  parameter int N_OUT = 3,
  parameter int W_W   = 8,
  parameter int B_W   = 16,
  parameter logic [N_HID*N_IN*W_W-1:0]  W0 = ENERGY2_W0,
  parameter logic [N_HID*B_W-1:0]       B0 = ENERGY2_B0,
  parameter logic [N_OUT*N_HID*W_W-1:0] W1 = ENERGY2_W1,
  parameter logic [N_OUT*B_W-1:0]       B1 = ENERGY2_B1,
  localparam int CLS_W = $clog2(N_OUT)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_IN*IN_W-1:0] inp,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [CLS_W-1:0]     out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy
);

  localparam int ACC_W   = hid_acc_w(B_W, W_W, IN_W, N_IN);
  localparam int HID_W   = ACC_W - 1;
  localparam int OACC_W  = out_acc_w(B_W, W_W, HID_W, N_HID);
  localparam int SCORE_W = OACC_W - 1;
  localparam int AW      = max_int(ACC_W, OACC_W);
  localparam int CW      = cnt_w(N_IN, N_HID, N_OUT);

  state_t state, state_next;

  logic [CW-1:0]          term_idx, neu_idx;
  logic [N_IN*IN_W-1:0]   x_reg;
  logic [N_HID*HID_W-1:0] hid;
  logic signed [AW-1:0]   acc;

  logic                   accept, last_term, last_neu, score_upd;
  logic [W_W-1:0]         w_raw;
  logic [B_W-1:0]         b_raw;
  logic [IN_W-1:0]        x_sel;
  logic [HID_W-1:0]       h_sel, hid_relu;
  logic [SCORE_W-1:0]     score;
  logic signed [AW-1:0]   w_ext, x_ext, b_ext, prod, acc_sum;

  always_comb begin
    state_next = state;
    in_ready   = (state == IDLE);
    busy       = (state != IDLE);
    out_valid  = (state == DONE);
    accept     = in_valid && (state == IDLE);
    case (state)
      IDLE:    if (accept) state_next = L0;
      L0:      if (last_term && last_neu) state_next = L1;
      L1:      if (last_term && last_neu) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Operand selection: term_idx walks inputs (L0) or hidden units (L1),
  // neu_idx walks the neuron currently being accumulated.
  always_comb begin
    last_term = 1'b0;
    last_neu  = 1'b0;
    x_sel     = x_reg[term_idx*IN_W +: IN_W];
    h_sel     = hid[term_idx*HID_W +: HID_W];
    w_raw     = '0;
    x_ext     = '0;
    b_raw     = '0;
    if (state == L1) begin
      last_term = (term_idx == CW'(N_HID - 1));
      last_neu  = (neu_idx == CW'(N_OUT - 1));
      w_raw     = W1[(neu_idx*N_HID + term_idx)*W_W +: W_W];
      x_ext     = {{(AW-HID_W){1'b0}}, h_sel};
    end else begin
      last_term = (term_idx == CW'(N_IN - 1));
      last_neu  = (neu_idx == CW'(N_HID - 1));
      w_raw     = W0[(neu_idx*N_IN + term_idx)*W_W +: W_W];
      x_ext     = {{(AW-IN_W){1'b0}}, x_sel};
    end
    case (state)
      IDLE: b_raw = B0[B_W-1:0];
      L0: begin
        if (last_neu) b_raw = B1[B_W-1:0];
        else          b_raw = B0[(32'(neu_idx) + 1)*B_W +: B_W];
      end
      L1: if (!last_neu) b_raw = B1[(32'(neu_idx) + 1)*B_W +: B_W];
      default: b_raw = '0;
    endcase
    w_ext     = {{(AW-W_W){w_raw[W_W-1]}}, w_raw};
    b_ext     = {{(AW-B_W){b_raw[B_W-1]}}, b_raw};
    prod      = w_ext * x_ext;
    acc_sum   = acc + prod;
    hid_relu  = acc_sum[AW-1] ? '0 : acc_sum[HID_W-1:0];
    score     = acc_sum[AW-1] ? '0 : acc_sum[SCORE_W-1:0];
    score_upd = (state == L1) && last_term;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_reg    <= '0;
      acc      <= '0;
      hid      <= '0;
      term_idx <= '0;
      neu_idx  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            x_reg    <= inp;
            acc      <= b_ext;
            term_idx <= '0;
            neu_idx  <= '0;
          end
        end
        L0: begin
          if (last_term) begin
            hid[neu_idx*HID_W +: HID_W] <= hid_relu;
            acc      <= b_ext;
            term_idx <= '0;
            neu_idx  <= last_neu ? '0 : neu_idx + 1'b1;
          end else begin
            acc      <= acc_sum;
            term_idx <= term_idx + 1'b1;
          end
        end
        L1: begin
          if (last_term) begin
            acc      <= b_ext;
            term_idx <= '0;
            neu_idx  <= last_neu ? '0 : neu_idx + 1'b1;
          end else begin
            acc      <= acc_sum;
            term_idx <= term_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  mlp_argmax_acc #(
    .SCORE_W (SCORE_W),
    .IDX_W   (CLS_W)
  ) u_argmax (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (accept),
    .update   (score_upd),
    .score    (score),
    .idx      (neu_idx[CLS_W-1:0]),
    .best_idx (out)
  );

endmodule

`default_nettype wire

// File: doc/mlp_seq_engine.md
MLP_SEQ_ENGINE -- requirements
Module: mlp_seq_engine

Interface
- REQ-001 N_IN, default 8, number of input features.
- REQ-002 IN_W, default 4, unsigned width of each input feature.
- REQ-003 N_HID, default 3, number of hidden neurons.
- REQ-004 N_OUT, default 3, number of classes, N_OUT >= 2.
- REQ-005 W_W, default 8, signed two's-complement width of each weight.
- REQ-006 B_W, default 16, signed bias width.
- REQ-007 W0/B0/W1/B1, default ENERGY2_W0/B0/W1/B1 package constants, layer coefficients. Flat arrays: W0 index is h*N_IN+i; W1 index is o*N_HID+h.
- REQ-008 Clocking and reset: one clock; reset is synchronous and active-low.
- REQ-009 clk  in  1  sole clock, all state updates on rising edge.
- REQ-010 rst_n  in  1  synchronous active-low reset.
- REQ-011 inp  in  N_IN*IN_W  features; feature i occupies bits [i*IN_W +: IN_W].
- REQ-012 in_valid  in  1  inp is valid.
- REQ-013 in_ready  out  1  engine can accept a sample.
- REQ-014 out  out  CLS_W=$clog2(N_OUT)  winning class index.
- REQ-015 out_valid  out  1  out holds a result.
- REQ-016 out_ready  in  1  consumer accepts the result.
- REQ-017 busy  out  1  asserted whenever the FSM is not IDLE.

Function
- REQ-018 The FSM SHALL have four states: IDLE, L0, L1, DONE.
- REQ-019 in_ready SHALL be high only in IDLE.
- REQ-020 Input accept occurs when in_valid && in_ready at an edge. At that edge the engine SHALL register inp, load acc=B0[0], and enter L0.
- REQ-021 L0 SHALL perform one MAC per cycle: acc += W0[h*N_IN+i]*{0,x_i}. i counts 0..N_IN-1 for each h in 0..N_HID-1.
- REQ-022 When i=N_IN-1 in L0, the engine SHALL write hid[h]=ReLU(acc incl. final product) and reload acc=B0[h+1]. When h=N_HID-1 it SHALL instead load B1[0] and enter L1.
- REQ-023 L1 SHALL perform one MAC per cycle: acc += W1[o*N_HID+h]*{0,hid[h]}.
- REQ-024 On the last hidden term of each output neuron in L1, the engine SHALL form score=ReLU(acc) and update the running argmax. After o=N_OUT-1 it SHALL enter DONE.
- REQ-025 The argmax SHALL use an unsigned compare of scores. Output 0 is the initial best, and the best is replaced only when score > best, so ties resolve to the lowest index.
- REQ-026 Latency SHALL be N_HID*N_IN + N_OUT*N_HID cycles from the accepting edge to out_valid high; the default is 33.
- REQ-027 In DONE, out_valid=1 and out SHALL be held stable until out_ready.
- REQ-028 DONE with out_ready=1 SHALL return to IDLE next cycle. out_ready outside DONE SHALL be ignored.
- REQ-029 in_valid during L0, L1 or DONE SHALL be ignored; no sample is queued.
- REQ-030 Arithmetic SHALL be exact with no saturation:
  - hidden ACC_W = B_W + W_W + IN_W + $clog2(N_IN) + 1
  - hidden activation HID_W = ACC_W - 1, unsigned
  - output accumulator OACC_W = max(B_W, W_W+HID_W+1) + $clog2(N_HID) + 1
- REQ-031 Coefficient selection SHALL be a combinational index into parameter arrays; no weight storage is writable.

Reset
- REQ-032 With rst_n=0 at an edge: state=IDLE, in_ready=1, out_valid=0, out=0, busy=0, counters=0, acc=0, hid=0.
- REQ-033 Reset asserted in any state, including mid-L0/L1 or DONE, SHALL abort the computation. No out_valid SHALL follow.
- REQ-034 rst_n SHALL take priority over all handshakes in the same cycle.

Structure
- REQ-035 Package mlp_seq_pkg SHALL hold the ENERGY2_W0/B0/W1/B1 constants, the state enum type, and width helper functions.
- REQ-036 One sub-module, mlp_argmax_acc, SHALL hold the running best score and index, with clear/update ports.
- REQ-037 The MAC datapath and FSM SHALL stay in mlp_seq_engine.

Verification
- REQ-038 Defaults, inp=32'h0 -> hid=(473,0,407), scores=(18800,22658,0), out=1 after 33 cycles.
- REQ-039 Defaults, inp=32'hFFFFFFFF -> hid=(0,798,0), scores=(0,0,26180), out=2.
- REQ-040 Tie: parameters giving scores (0,0,0) -> out=0. Parameters giving equal scores for outputs 1 and 2, both above output 0 -> out=1.
- REQ-041 Backpressure: hold out_ready=0 for 10 cycles in DONE -> out and out_valid stable, in_ready=0. Then out_ready=1 -> IDLE next cycle.
- REQ-042 Reset mid-L1 (cycle 28) -> all outputs at reset values next cycle. A new sample accepted afterwards SHALL produce the correct result.
- REQ-043 Randomized 10k samples, including N_IN=16, IN_W=8, N_HID=5, N_OUT=4 -> out matches a bit-exact golden model.
